// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches under a credit limit,
// buffers returned words with their PCs, and flushes/redirects on branch.
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  output logic        o_MemReqValid,
  output logic [31:0] o_MemReqAddr,
  input  logic        i_MemReqReady,
  input  logic        i_MemRespValid,
  input  logic [31:0] i_MemRespData,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC,
  input  logic        i_Ready,
  output logic        o_InstructionWordValid,
  output logic [31:0] o_InstructionWord,
  output logic [31:0] o_PC,
  output logic [31:0] o_NextPC,
  output logic        o_InstructionAddressMisaligned
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_S  = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        misaligned;
  } entry_t;

  entry_t        q_mem  [DEPTH];
  logic [31:0]   oa_mem [DEPTH];

  logic [PW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  logic [PW-1:0] oa_rd_q, oa_rd_d, oa_wr_q, oa_wr_d;
  logic [CW-1:0] q_cnt_q, q_cnt_d, out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic          hold_q, hold_d, pend_q, pend_d;

  logic   credit_ok, req_fire, resp_fire, dropping;
  logic   resp_enq, fault_enq, enq, deq;
  entry_t head, enq_entry;

  // Requests + outstanding + queued never exceed DEPTH, so a response always finds room.
  assign credit_ok = ({1'b0, q_cnt_q} + {1'b0, out_cnt_q}) < DEPTH_S;

  assign o_MemReqValid = i_Reset && credit_ok && !i_Redirect && !hold_q;
  assign o_MemReqAddr  = pc_q;

  assign req_fire  = o_MemReqValid && i_MemReqReady;
  assign resp_fire = i_MemRespValid && (out_cnt_q != '0);
  assign dropping  = (drop_cnt_q != '0);
  assign resp_enq  = resp_fire && !dropping && !i_Redirect;
  assign fault_enq = pend_q && !dropping && !i_Redirect;
  assign enq       = resp_enq || fault_enq;

  assign head = q_mem[q_rd_q];

  assign o_InstructionWordValid         = (q_cnt_q != '0);
  assign o_InstructionWord              = o_InstructionWordValid ? head.word : '0;
  assign o_PC                           = o_InstructionWordValid ? head.pc : pc_q;
  assign o_NextPC                       = o_PC + 32'd4;
  assign o_InstructionAddressMisaligned = o_InstructionWordValid && head.misaligned;

  assign deq = o_InstructionWordValid && i_Ready && !i_Redirect;

  // A held fault fetches nothing, so pc_q still holds the faulting redirect target.
  always_comb begin
    enq_entry = '{word: i_MemRespData, pc: oa_mem[oa_rd_q], misaligned: 1'b0};
    if (fault_enq) begin
      enq_entry = '{word: NOP_WORD, pc: pc_q, misaligned: 1'b1};
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    q_rd_d     = q_rd_q;
    q_wr_d     = q_wr_q;
    oa_rd_d    = oa_rd_q;
    oa_wr_d    = oa_wr_q;
    q_cnt_d    = q_cnt_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    pend_d     = pend_q;

    if (req_fire)  oa_wr_d = oa_wr_q + PW'(1);
    if (resp_fire) oa_rd_d = oa_rd_q + PW'(1);
    case ({req_fire, resp_fire})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    if (i_Redirect) begin
      pc_d       = i_RedirectPC;
      q_rd_d     = q_wr_q;
      q_cnt_d    = '0;
      drop_cnt_d = resp_fire ? out_cnt_q - CW'(1) : out_cnt_q;
      hold_d     = |i_RedirectPC[1:0];
      pend_d     = |i_RedirectPC[1:0];
    end else begin
      if (req_fire)             pc_d       = pc_q + 32'd4;
      if (resp_fire && dropping) drop_cnt_d = drop_cnt_q - CW'(1);
      if (fault_enq)            pend_d     = 1'b0;
      if (enq)                  q_wr_d     = q_wr_q + PW'(1);
      if (deq)                  q_rd_d     = q_rd_q + PW'(1);
      case ({enq, deq})
        2'b10:   q_cnt_d = q_cnt_q + CW'(1);
        2'b01:   q_cnt_d = q_cnt_q - CW'(1);
        default: q_cnt_d = q_cnt_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments and clear asynchronously on i_Reset low.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      oa_rd_q    <= '0;
      oa_wr_q    <= '0;
      q_cnt_q    <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      pc_q       <= RESET_PC;
      hold_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      oa_rd_q    <= oa_rd_d;
      oa_wr_q    <= oa_wr_d;
      q_cnt_q    <= q_cnt_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
    end
  end

  // NOTE: storage arrays are not reset; counts gate every read, so stale contents are never visible.
  always_ff @(posedge i_Clock) begin
    if (req_fire) oa_mem[oa_wr_q] <= o_MemReqAddr;
    if (enq)      q_mem[q_wr_q]   <= enq_entry;
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: a queue-level reference model plus a
// latency-configurable memory, compared every cycle, with literal spot checks.
module tb_instruction_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        i_Reset;
  logic        o_MemReqValid;
  logic [31:0] o_MemReqAddr;
  logic        i_MemReqReady;
  logic        i_MemRespValid;
  logic [31:0] i_MemRespData;
  logic        i_Redirect;
  logic [31:0] i_RedirectPC;
  logic        i_Ready;
  logic        o_InstructionWordValid;
  logic [31:0] o_InstructionWord;
  logic [31:0] o_PC;
  logic [31:0] o_NextPC;
  logic        o_InstructionAddressMisaligned;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_Clock                        (clk),
    .i_Reset                        (i_Reset),
    .o_MemReqValid                  (o_MemReqValid),
    .o_MemReqAddr                   (o_MemReqAddr),
    .i_MemReqReady                  (i_MemReqReady),
    .i_MemRespValid                 (i_MemRespValid),
    .i_MemRespData                  (i_MemRespData),
    .i_Redirect                     (i_Redirect),
    .i_RedirectPC                   (i_RedirectPC),
    .i_Ready                        (i_Ready),
    .o_InstructionWordValid         (o_InstructionWordValid),
    .o_InstructionWord              (o_InstructionWord),
    .o_PC                           (o_PC),
    .o_NextPC                       (o_NextPC),
    .o_InstructionAddressMisaligned (o_InstructionAddressMisaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  // Reference model state: delivered queue, outstanding addresses, drop count, fault state.
  ent_t        mq[$];
  logic [31:0] mo[$];
  int          m_drop = 0;
  bit          m_hold = 0;
  bit          m_pend = 0;
  logic [31:0] m_pc   = RESET_PC;

  // Memory environment.
  mreq_t       env_q[$];
  logic [31:0] req_log[$];
  int          cyc       = 0;
  int          mem_lat   = 1;
  bit          spurious  = 0;
  bit          env_drive = 0;
  bit          dut_fire  = 0;
  logic [31:0] dut_addr  = '0;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic bit m_req_valid();
    return (i_Reset === 1'b1) && (mq.size() + mo.size() < DEPTH) && !i_Redirect && !m_hold;
  endfunction

  // Per-cycle comparison of DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    dut_fire = (o_MemReqValid === 1'b1) && (i_MemReqReady === 1'b1);
    if (dut_fire) dut_addr = o_MemReqAddr;
    if (i_Reset !== 1'b1) begin
      check("rst_req_valid", o_MemReqValid, 0);
      check("rst_iw_valid", o_InstructionWordValid, 0);
      check("rst_misaligned", o_InstructionAddressMisaligned, 0);
      check("rst_pc", o_PC, RESET_PC);
      check("rst_next_pc", o_NextPC, RESET_PC + 32'd4);
      check("rst_word", o_InstructionWord, 0);
    end else begin
      check("req_valid", o_MemReqValid, m_req_valid());
      if (m_req_valid()) check("req_addr", o_MemReqAddr, m_pc);
      check("iw_valid", o_InstructionWordValid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("word", o_InstructionWord, mq[0].word);
        check("pc", o_PC, mq[0].pc);
        check("next_pc", o_NextPC, mq[0].pc + 32'd4);
        check("misaligned", o_InstructionAddressMisaligned, mq[0].mis);
      end
    end
  end

  // One clock: update model and memory at the edge, then drive the next response.
  task automatic tick();
    bit          rv, resp, fenq, deq;
    logic [31:0] a;
    @(posedge clk);
    if (i_Reset !== 1'b1) begin
      mq.delete();
      mo.delete();
      m_drop = 0;
      m_hold = 0;
      m_pend = 0;
      m_pc   = RESET_PC;
      env_q.delete();
    end else begin
      rv   = m_req_valid() && i_MemReqReady;
      resp = i_MemRespValid && (mo.size() > 0);
      if (i_Redirect) begin
        if (resp) void'(mo.pop_front());
        mq.delete();
        m_pc   = i_RedirectPC;
        m_drop = mo.size();
        m_hold = |i_RedirectPC[1:0];
        m_pend = m_hold;
      end else begin
        fenq = m_pend && (m_drop == 0);
        deq  = (mq.size() > 0) && i_Ready;
        if (deq) void'(mq.pop_front());
        if (resp) begin
          a = mo.pop_front();
          if (m_drop > 0) m_drop--;
          else mq.push_back('{mem_word(a), a, 1'b0});
        end else if (fenq) begin
          mq.push_back('{32'h0000_0013, m_pc, 1'b1});
          m_pend = 0;
        end
        if (rv) begin
          mo.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      if (env_drive && i_MemRespValid) void'(env_q.pop_front());
      if (dut_fire) begin
        env_q.push_back('{dut_addr, cyc + mem_lat});
        req_log.push_back(dut_addr);
      end
    end
    cyc++;
    #1;
    env_drive      = (env_q.size() > 0) && (env_q[0].due <= cyc);
    i_MemRespValid = spurious || env_drive;
    i_MemRespData  = env_drive ? mem_word(env_q[0].addr) : 32'h0;
  endtask

  task automatic do_reset();
    i_Reset    = 1'b0;
    i_Redirect = 1'b0;
    spurious   = 0;
    tick();
    tick();
    req_log.delete();
    i_Reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    i_Redirect   = 1'b1;
    i_RedirectPC = target;
    tick();
    i_Redirect = 1'b0;
    #2;
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    while (o_InstructionWordValid !== 1'b1 && n < max) begin
      tick();
      #2;
      n++;
    end
    check(name, o_InstructionWordValid, 1);
  endtask

  initial begin
    i_Reset        = 1'b0;
    i_MemReqReady  = 1'b0;
    i_MemRespValid = 1'b0;
    i_MemRespData  = '0;
    i_Redirect     = 1'b0;
    i_RedirectPC   = '0;
    i_Ready        = 1'b0;

    #3;
    check("init_req_valid", o_MemReqValid, 0);
    check("init_pc", o_PC, 32'h0);
    check("init_next_pc", o_NextPC, 32'h4);

    // Back-to-back fetch with latency-1 memory and a consuming decoder.
    i_MemReqReady = 1'b1;
    i_Ready       = 1'b1;
    mem_lat       = 1;
    do_reset();
    #2;
    check("p1_req0_valid", o_MemReqValid, 1);
    check("p1_req0_addr", o_MemReqAddr, 32'h0);
    tick(); #2;
    check("p1_req1_addr", o_MemReqAddr, 32'h4);
    check("p1_c1_iw_valid", o_InstructionWordValid, 0);
    tick(); #2;
    check("p1_req2_addr", o_MemReqAddr, 32'h8);
    check("p1_c2_iw_valid", o_InstructionWordValid, 1);
    check("p1_c2_pc", o_PC, 32'h0);
    check("p1_c2_next_pc", o_NextPC, 32'h4);
    check("p1_c2_word", o_InstructionWord, 32'h5A5A_A5A5);
    repeat (6) tick();

    // Stalled decoder fills the queue; draining releases credits.
    i_Ready = 1'b0;
    do_reset();
    repeat (8) tick();
    #2;
    check("p2_req_count", req_log.size(), 4);
    check("p2_full_req_valid", o_MemReqValid, 0);
    i_Ready = 1'b1;
    check("p2_drain0_pc", o_PC, 32'h0);
    tick(); #2;
    check("p2_drain1_pc", o_PC, 32'h4);
    tick(); #2;
    check("p2_drain2_pc", o_PC, 32'h8);
    tick(); #2;
    check("p2_drain3_pc", o_PC, 32'hC);
    repeat (6) tick();
    #2;
    check("p2_resume_addr", (req_log.size() > 4) ? req_log[4] : 32'hDEAD_DEAD, 32'h10);

    // Redirect with three requests in flight on a latency-3 memory.
    mem_lat = 3;
    do_reset();
    repeat (3) tick();
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h100;
    #1;
    check("p3_redirect_no_req", o_MemReqValid, 0);
    tick();
    i_Redirect = 1'b0;
    #2;
    check("p3_flushed", o_InstructionWordValid, 0);
    wait_valid(20, "p3_wait_valid");
    check("p3_first_pc", o_PC, 32'h100);

    // Misaligned redirect, then recovery by a second redirect.
    mem_lat = 1;
    i_Ready = 1'b0;
    redirect(32'h102);
    check("p4_no_req", o_MemReqValid, 0);
    wait_valid(10, "p4_wait_valid");
    check("p4_pc", o_PC, 32'h102);
    check("p4_next_pc", o_NextPC, 32'h106);
    check("p4_misaligned", o_InstructionAddressMisaligned, 1);
    check("p4_word", o_InstructionWord, 32'h0000_0013);
    repeat (3) tick();
    #2;
    check("p4_halted", o_MemReqValid, 0);
    check("p4_single_entry_held", o_InstructionWordValid, 1);
    redirect(32'h200);
    check("p4_resume_valid", o_MemReqValid, 1);
    check("p4_resume_addr", o_MemReqAddr, 32'h200);

    // Fetch PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    check("p5_top_addr", o_MemReqAddr, 32'hFFFF_FFFC);
    tick(); #2;
    check("p5_wrap_addr", o_MemReqAddr, 32'h0);
    wait_valid(10, "p5_wait_valid");
    check("p5_pc", o_PC, 32'hFFFF_FFFC);
    check("p5_next_pc", o_NextPC, 32'h0);

    // A response with nothing outstanding is ignored.
    i_MemReqReady = 1'b0;
    do_reset();
    spurious       = 1;
    i_MemRespValid = 1'b1;
    i_MemRespData  = 32'h1234_5678;
    tick();
    spurious = 0;
    tick(); #2;
    check("p6_spurious_ignored", o_InstructionWordValid, 0);
    i_MemReqReady = 1'b1;
    i_Ready       = 1'b1;
    repeat (10) tick();

    // Mixed traffic: intermittent decoder and memory stalls with latency 2.
    mem_lat = 2;
    for (int i = 0; i < 30; i++) begin
      i_Ready       = (i % 3) != 0;
      i_MemReqReady = (i % 5) != 2;
      if (i == 17) begin
        i_Redirect   = 1'b1;
        i_RedirectPC = 32'h0000_0400;
      end else begin
        i_Redirect = 1'b0;
      end
      tick();
    end
    i_Redirect    = 1'b0;
    i_MemReqReady = 1'b1;

    // Asynchronous reset mid-cycle with a full queue.
    mem_lat = 1;
    i_Ready = 1'b0;
    repeat (8) tick();
    #2;
    check("p7_full_valid", o_InstructionWordValid, 1);
    i_Reset = 1'b0;
    #1;
    check("p7_async_req_valid", o_MemReqValid, 0);
    check("p7_async_iw_valid", o_InstructionWordValid, 0);
    check("p7_async_misaligned", o_InstructionAddressMisaligned, 0);
    check("p7_async_pc", o_PC, RESET_PC);
    check("p7_async_next_pc", o_NextPC, RESET_PC + 32'd4);
    check("p7_async_word", o_InstructionWord, 0);
    tick();
    tick();
    i_Reset = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of queued instruction entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 i_Clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_Reset  in  1  asynchronous, active-low reset.
REQ-006 o_MemReqValid  out  1  instruction-memory read request valid.
REQ-007 o_MemReqAddr  out  32  word address of the request.
REQ-008 i_MemReqReady  in  1  memory accepts the request this cycle.
REQ-009 i_MemRespValid  in  1  read data returned; responses are in request order, latency 1 cycle or more.
REQ-010 i_MemRespData  in  32  returned instruction word.
REQ-011 i_Redirect  in  1  branch/jump redirect from decode.
REQ-012 i_RedirectPC  in  32  new fetch address.
REQ-013 i_Ready  in  1  decode consumes the head entry this cycle.
REQ-014 o_InstructionWordValid  out  1  head entry valid.
REQ-015 o_InstructionWord  out  32  head instruction word.
REQ-016 o_PC  out  32  address of the head word.
REQ-017 o_NextPC  out  32  o_PC + 4, modulo 2^32.
REQ-018 o_InstructionAddressMisaligned  out  1  head entry carries a misaligned-PC fault.

Function
REQ-019 Fetch PC register SHALL issue o_MemReqValid when (occupancy + outstanding) < DEPTH, no redirect is asserted, and no fault is held.
REQ-020 A handshake (o_MemReqValid and i_MemReqReady) SHALL increment fetch PC by 4 (wrapping at 2^32) and push the request address to an outstanding-address FIFO.
REQ-021 Each i_MemRespValid SHALL pop the oldest outstanding address and enqueue {word, address} into the queue, unless the drop counter is nonzero.
REQ-022 The queue SHALL be a FIFO of DEPTH entries; the head is presented combinationally on o_InstructionWord, o_PC, o_NextPC.
REQ-023 A dequeue SHALL occur when o_InstructionWordValid and i_Ready are both high; an enqueue and a dequeue in the same cycle SHALL leave occupancy unchanged.
REQ-024 Credit accounting SHALL guarantee that a response never arrives while the queue is full; no back-pressure to memory is provided.
REQ-025 On i_Redirect, the queue SHALL be emptied, fetch PC set to i_RedirectPC, and the drop counter set to the number of outstanding requests, excluding any response popped in the same cycle.
REQ-026 While the drop counter is nonzero, each response SHALL be discarded and the counter decremented by 1.
REQ-027 A redirect SHALL take priority over a same-cycle enqueue, dequeue, or request; no request is issued in the redirect cycle.
REQ-028 If i_RedirectPC[1:0] is nonzero, no memory request SHALL be issued. Once drops complete, a single entry SHALL be enqueued with PC = i_RedirectPC, word 32'h0000_0013, and the misaligned flag set; fetching stays halted until the next redirect.
REQ-029 The outstanding count SHALL never exceed DEPTH.
REQ-030 An i_MemRespValid arriving with zero outstanding requests SHALL be ignored.

Reset
REQ-031 While i_Reset=0, all state SHALL clear asynchronously: fetch PC = RESET_PC; queue, outstanding, and drop counts = 0; misaligned hold = 0.
REQ-032 During reset, o_MemReqValid=0, o_InstructionWordValid=0, o_InstructionAddressMisaligned=0, o_PC=RESET_PC, o_NextPC=RESET_PC+4, and o_InstructionWord=0.
REQ-033 The first request SHALL be issued in the first clock edge after reset deasserts; in-flight responses from before reset SHALL be the environment's responsibility.

Verification
REQ-034 Reset release, ready memory with latency 1, i_Ready=1 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; first valid word with o_PC=0x0 and o_NextPC=0x4 two cycles after the first request.
REQ-035 i_Ready=0, memory always ready -> exactly 4 requests (0x0..0xC), then o_MemReqValid=0; queue holds 4 entries; raising i_Ready drains them in order, then requests resume at 0x10.
REQ-036 Memory latency 3 with 3 outstanding requests, redirect to 0x100 -> 3 responses discarded, queue empty; next delivered o_PC=0x100.
REQ-037 Redirect to 0x102 -> no memory request; one entry with o_PC=0x102, o_InstructionAddressMisaligned=1, word 0x00000013; redirect to 0x200 then resumes fetching.
REQ-038 Fetch PC at 0xFFFFFFFC -> next request address 0x00000000, and o_NextPC of the 0xFFFFFFFC entry = 0x00000000.
REQ-039 Reset asserted asynchronously mid-cycle with queue full -> outputs return to reset values immediately, before the next clock edge.
